dispatch_rf_controller: RTL and testbench
=========================================

Name: dispatch_rf_controller

Overview:
Next-generation register-file controller with tag tracking. It owns the architectural register array, and each register holds either a value (valid=1) or a pending CDB tag (valid=0). It sits between decode and N ALU execution units. It dispatches ALU, IMM, COPY and OUT micro-ops using valid/ready handshakes, snoops the CDB to resolve pending registers, and drives a registered output port for OUT.

Parameters:
REGISTER_COUNT, 8, number of architectural registers; a power of two, at least 2.
DATA_WIDTH, 4, data word width.
CDB_TAG_WIDTH, 4, CDB tag width; must be at most DATA_WIDTH.
UOP_COMMAND_WIDTH, 3, micro-op kind width.
EU_COUNT, 2, number of ALU execution units; 1 to 8.
ACC_INDEX, 0, destination register for ALU and IMM results.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cdb_in_valid  in  1  CDB broadcast valid
cdb_in_tag  in  CDB_TAG_WIDTH  CDB tag
cdb_in_data  in  DATA_WIDTH  CDB data
cmd_valid  in  1  decode presents a micro-op
cmd_ready  out  1  micro-op accepted this cycle when cmd_valid is also high
cmd_kind  in  UOP_COMMAND_WIDTH  NOP=0, ALU=1, IMM=2, COPY=3, OUT=4; other codes are treated as NOP
cmd_op1  in  log2(REGISTER_COUNT)  source register
cmd_op2  in  max(DATA_WIDTH, log2(REGISTER_COUNT))  second source register, immediate, or COPY destination
eu_issue_valid  out  EU_COUNT  one-hot issue strobe to the chosen execution unit
eu_issue_ready  in  EU_COUNT  execution unit can accept an issue
eu_result_tag  in  EU_COUNT*CDB_TAG_WIDTH  tag each execution unit will broadcast; execution unit i uses slice i
eu_op_a_data  out  DATA_WIDTH  operand A value or tag, shared by all execution units
eu_op_a_valid  out  1  operand A holds a value (1) or a tag (0)
eu_op_b_data  out  DATA_WIDTH  operand B value or tag
eu_op_b_valid  out  1  operand B holds a value (1) or a tag (0)
out_valid  out  1  OUT data available
out_data  out  DATA_WIDTH  OUT value, registered
out_ready  in  1  consumer accepts OUT data

Behaviour:
- Reset (asynchronous, rst_n low):
  - every register is value 0, valid=1;
  - FSM goes to IDLE;
  - out_valid=0, out_data=0;
  - eu_issue_valid=0.
  - Reset asserted mid-OUT drops the pending OUT.
- Fire rule: the command fires when cmd_valid && cmd_ready. Register updates take effect at the next clk edge.
- Register reads are combinational with CDB bypass. If the addressed register is pending and cdb_in_valid is high with a matching tag, the read returns cdb_in_data with valid=1.
- CDB snoop: every pending register whose tag equals cdb_in_tag takes cdb_in_data and sets valid=1, all in the same edge. Registers that are already valid are never modified by the CDB.
- A dispatch write and a CDB update to the same register in the same cycle: the dispatch write wins.
- NOP: cmd_ready=1 in IDLE; no state change.
- IMM: cmd_ready=1 in IDLE. R[ACC_INDEX] becomes cmd_op2[DATA_WIDTH-1:0] with valid=1.
- COPY: cmd_ready=1 in IDLE. R[cmd_op2[log2-1:0]] becomes the bypassed read of R[cmd_op1], value or tag, together with its valid bit. Copying a register onto itself is a no-op in effect.
- ALU:
  - Operands are the bypassed reads of R[cmd_op1] and R[cmd_op2[log2-1:0]]. Tags are zero-extended to DATA_WIDTH.
  - The selected execution unit is the lowest index i with eu_issue_ready[i]=1.
  - cmd_ready is the OR of eu_issue_ready, and only in IDLE.
  - eu_issue_valid[i]=1 only when cmd_valid && kind==ALU && in IDLE; this path is combinational.
  - On fire, R[ACC_INDEX] becomes eu_result_tag slice i with valid=0.
  - Operands read the pre-write ACC contents.
- OUT uses a three-state FSM:
  - IDLE: cmd_ready=1 for OUT. On fire, latch cmd_op1 as out_reg.
    - If the bypassed read is valid: out_data takes the value and the FSM goes to PRESENT.
    - Otherwise the FSM goes to WAIT.
  - WAIT: cmd_ready=0. Each cycle, if the bypassed read of R[out_reg] is valid: out_data takes it and the FSM goes to PRESENT.
  - PRESENT: out_valid=1 and cmd_ready=0. When out_ready is high, the FSM goes to IDLE.
  - out_valid rises exactly one cycle after the operand becomes available.
  - Register updates by the CDB during WAIT are observed.
- Whenever eu_issue_valid is 0, eu_op_* drive 0.

Decomposition:
- Shared package: micro-op kind constants, EFFECTIVE_REGISTER_WIDTH, COMMAND_OP2_SIZE, and the FSM state encoding (IDLE, WAIT, PRESENT).
- One sub-module: eu_issue_arbiter, a fixed-priority one-hot select over eu_issue_ready.
- Register array, CDB snoop and FSM stay in this module.

Test Plan:
- Reset, then IMM op2=5, then OUT op1=0 -> out_valid=1 exactly one cycle after the OUT fire, out_data=5.
- eu_issue_ready=2'b10, eu_result_tag slice1=3, ALU op1=1 op2=2 -> eu_issue_valid=2'b10, operands are 0/valid; R0 holds tag 3, valid=0.
- OUT op1=0 while R0 holds pending tag 3, cdb 3/9 two cycles later -> cmd_ready=0 during WAIT; out_data=9 one cycle after the CDB; holding out_ready=0 for 3 cycles keeps out_valid=1 with stable data.
- ALU issue, then COPY 0->4 in the same cycle the CDB broadcasts that tag with 7 -> R4 has valid=1, value 7 (bypass).
- IMM to ACC plus a CDB match on ACC's old tag in the same cycle -> ACC equals the immediate (dispatch wins); eu_issue_ready=0 with ALU pending -> cmd_ready=0 and no state change.
- Reset asserted asynchronously while in PRESENT -> out_valid=0 immediately and FSM in IDLE.

Source files
------------

// File: rtl/dispatch_rf_controller_pkg.sv
// Shared definitions for the dispatch register-file controller: micro-op codes,
// derived operand widths and the OUT-path state encoding.
package dispatch_rf_controller_pkg;

  localparam int UOP_NOP  = 0;
  localparam int UOP_ALU  = 1;
  localparam int UOP_IMM  = 2;
  localparam int UOP_COPY = 3;
  localparam int UOP_OUT  = 4;

  function automatic int eff_reg_width(input int reg_count);
    return (reg_count > 1) ? $clog2(reg_count) : 1;
  endfunction

  // op2 carries a register index, an immediate or a COPY destination.
  function automatic int op2_size(input int data_width, input int reg_count);
    return (data_width > eff_reg_width(reg_count)) ? data_width : eff_reg_width(reg_count);
  endfunction

  localparam int EFFECTIVE_REGISTER_WIDTH = eff_reg_width(8);
  localparam int COMMAND_OP2_SIZE         = op2_size(4, 8);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_PRESENT = 2'd2
  } rf_state_e;

endpackage

// File: rtl/dispatch_rf_controller_eu_issue_arbiter.sv
// Fixed-priority one-hot select: the lowest-indexed ready execution unit wins.
module dispatch_rf_controller_eu_issue_arbiter #(
  parameter int EU_COUNT = 2
) (
  input  logic [EU_COUNT-1:0] ready_i,
  output logic [EU_COUNT-1:0] grant_o,
  output logic                any_o
);

  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int i = 0; i < EU_COUNT; i++) begin
      if (ready_i[i] && !found) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any_o = |ready_i;

endmodule

// File: rtl/dispatch_rf_controller.sv
// Register file with value/tag tracking: dispatches micro-ops to execution units,
// snoops the CDB for pending registers and presents OUT results on a registered port.
module dispatch_rf_controller
  import dispatch_rf_controller_pkg::*;
#(
  parameter int REGISTER_COUNT    = 8,
  parameter int DATA_WIDTH        = 4,
  parameter int CDB_TAG_WIDTH     = 4,
  parameter int UOP_COMMAND_WIDTH = 3,
  parameter int EU_COUNT          = 2,
  parameter int ACC_INDEX         = 0,
  localparam int RW = eff_reg_width(REGISTER_COUNT),
  localparam int OW = op2_size(DATA_WIDTH, REGISTER_COUNT)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cdb_in_valid,
  input  logic [CDB_TAG_WIDTH-1:0]          cdb_in_tag,
  input  logic [DATA_WIDTH-1:0]             cdb_in_data,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [UOP_COMMAND_WIDTH-1:0]      cmd_kind,
  input  logic [RW-1:0]                     cmd_op1,
  input  logic [OW-1:0]                     cmd_op2,
  output logic [EU_COUNT-1:0]               eu_issue_valid,
  input  logic [EU_COUNT-1:0]               eu_issue_ready,
  input  logic [EU_COUNT*CDB_TAG_WIDTH-1:0] eu_result_tag,
  output logic [DATA_WIDTH-1:0]             eu_op_a_data,
  output logic                              eu_op_a_valid,
  output logic [DATA_WIDTH-1:0]             eu_op_b_data,
  output logic                              eu_op_b_valid,
  output logic                              out_valid,
  output logic [DATA_WIDTH-1:0]             out_data,
  input  logic                              out_ready,
  output rf_state_e                         dbg_state
);

  // Handshake: a micro-op is consumed on a clock edge where cmd_valid && cmd_ready;
  // an EU takes an issue where its eu_issue_valid bit is high (only ever a ready EU);
  // OUT data is consumed on an edge where out_valid && out_ready.

  localparam logic [UOP_COMMAND_WIDTH-1:0] K_ALU  = UOP_COMMAND_WIDTH'(UOP_ALU);
  localparam logic [UOP_COMMAND_WIDTH-1:0] K_IMM  = UOP_COMMAND_WIDTH'(UOP_IMM);
  localparam logic [UOP_COMMAND_WIDTH-1:0] K_COPY = UOP_COMMAND_WIDTH'(UOP_COPY);
  localparam logic [UOP_COMMAND_WIDTH-1:0] K_OUT  = UOP_COMMAND_WIDTH'(UOP_OUT);
  localparam logic [RW-1:0]                ACC    = RW'(ACC_INDEX);

  logic [DATA_WIDTH-1:0]     val_q [REGISTER_COUNT];
  logic [DATA_WIDTH-1:0]     val_d [REGISTER_COUNT];
  logic [REGISTER_COUNT-1:0] vld_q, vld_d;
  rf_state_e                 state_q, state_d;
  logic [RW-1:0]             out_reg_q, out_reg_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;

  // Pending registers hold their tag in the low bits of the value field.
  function automatic logic [DATA_WIDTH:0] bypass(
    input logic [DATA_WIDTH-1:0]    v,
    input logic                     vld,
    input logic                     cdb_v,
    input logic [CDB_TAG_WIDTH-1:0] cdb_t,
    input logic [DATA_WIDTH-1:0]    cdb_d
  );
    if (vld) return {1'b1, v};
    if (cdb_v && (v[CDB_TAG_WIDTH-1:0] == cdb_t)) return {1'b1, cdb_d};
    return {1'b0, v};
  endfunction

  logic [DATA_WIDTH:0] rd_a, rd_b, rd_o;
  logic [RW-1:0]       op2_reg;

  assign op2_reg = cmd_op2[RW-1:0];
  assign rd_a = bypass(val_q[cmd_op1], vld_q[cmd_op1], cdb_in_valid, cdb_in_tag, cdb_in_data);
  assign rd_b = bypass(val_q[op2_reg], vld_q[op2_reg], cdb_in_valid, cdb_in_tag, cdb_in_data);
  assign rd_o = bypass(val_q[out_reg_q], vld_q[out_reg_q], cdb_in_valid, cdb_in_tag, cdb_in_data);

  logic is_alu, is_imm, is_copy, is_out, idle, fire, issue;
  logic [EU_COUNT-1:0]      grant;
  logic                     eu_any;
  logic [CDB_TAG_WIDTH-1:0] sel_tag;

  assign is_alu  = (cmd_kind == K_ALU);
  assign is_imm  = (cmd_kind == K_IMM);
  assign is_copy = (cmd_kind == K_COPY);
  assign is_out  = (cmd_kind == K_OUT);
  assign idle    = (state_q == ST_IDLE);

  dispatch_rf_controller_eu_issue_arbiter #(.EU_COUNT(EU_COUNT)) u_arb (
    .ready_i (eu_issue_ready),
    .grant_o (grant),
    .any_o   (eu_any)
  );

  always_comb begin
    sel_tag = '0;
    for (int i = 0; i < EU_COUNT; i++) begin
      if (grant[i]) sel_tag = sel_tag | eu_result_tag[i*CDB_TAG_WIDTH +: CDB_TAG_WIDTH];
    end
  end

  assign cmd_ready      = idle && (!is_alu || eu_any);
  assign fire           = cmd_valid && cmd_ready;
  assign issue          = cmd_valid && is_alu && idle && eu_any;
  assign eu_issue_valid = issue ? grant : '0;
  assign eu_op_a_data   = issue ? rd_a[DATA_WIDTH-1:0] : '0;
  assign eu_op_a_valid  = issue ? rd_a[DATA_WIDTH] : 1'b0;
  assign eu_op_b_data   = issue ? rd_b[DATA_WIDTH-1:0] : '0;
  assign eu_op_b_valid  = issue ? rd_b[DATA_WIDTH] : 1'b0;

  // CDB snoop first, then the dispatch write so it overrides a same-cycle CDB hit.
  always_comb begin
    vld_d = vld_q;
    for (int r = 0; r < REGISTER_COUNT; r++) begin
      val_d[r] = val_q[r];
      if (cdb_in_valid && !vld_q[r] && (val_q[r][CDB_TAG_WIDTH-1:0] == cdb_in_tag)) begin
        val_d[r] = cdb_in_data;
        vld_d[r] = 1'b1;
      end
    end
    if (fire) begin
      if (is_imm) begin
        val_d[ACC] = cmd_op2[DATA_WIDTH-1:0];
        vld_d[ACC] = 1'b1;
      end else if (is_alu) begin
        val_d[ACC] = DATA_WIDTH'(sel_tag);
        vld_d[ACC] = 1'b0;
      end else if (is_copy) begin
        val_d[op2_reg] = rd_a[DATA_WIDTH-1:0];
        vld_d[op2_reg] = rd_a[DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    out_reg_d  = out_reg_q;
    out_data_d = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (fire && is_out) begin
          out_reg_d = cmd_op1;
          if (rd_a[DATA_WIDTH]) begin
            out_data_d = rd_a[DATA_WIDTH-1:0];
            state_d    = ST_PRESENT;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (rd_o[DATA_WIDTH]) begin
          out_data_d = rd_o[DATA_WIDTH-1:0];
          state_d    = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < REGISTER_COUNT; r++) val_q[r] <= '0;
      vld_q      <= '1;
      state_q    <= ST_IDLE;
      out_reg_q  <= '0;
      out_data_q <= '0;
    end else begin
      val_q      <= val_d;
      vld_q      <= vld_d;
      state_q    <= state_d;
      out_reg_q  <= out_reg_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_valid = (state_q == ST_PRESENT);
  assign out_data  = out_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dispatch_rf_controller.sv
// Randomised bench for dispatch_rf_controller against a behavioural register-file
// model, plus directed scenarios with hand-computed expectations.
module tb_dispatch_rf_controller;
  import dispatch_rf_controller_pkg::*;

  localparam int RC = 8;
  localparam int DW = 4;
  localparam int TW = 4;
  localparam int KW = 3;
  localparam int EC = 2;
  localparam int AW = 3;
  localparam int OW = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cdb_in_valid;
  logic [TW-1:0]    cdb_in_tag;
  logic [DW-1:0]    cdb_in_data;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [KW-1:0]    cmd_kind;
  logic [AW-1:0]    cmd_op1;
  logic [OW-1:0]    cmd_op2;
  logic [EC-1:0]    eu_issue_valid;
  logic [EC-1:0]    eu_issue_ready;
  logic [EC*TW-1:0] eu_result_tag;
  logic [DW-1:0]    eu_op_a_data;
  logic             eu_op_a_valid;
  logic [DW-1:0]    eu_op_b_data;
  logic             eu_op_b_valid;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_ready;
  rf_state_e        dbg_state;

  int errors = 0;
  int checks = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dispatch_rf_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cdb_in_valid   (cdb_in_valid),
    .cdb_in_tag     (cdb_in_tag),
    .cdb_in_data    (cdb_in_data),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_kind       (cmd_kind),
    .cmd_op1        (cmd_op1),
    .cmd_op2        (cmd_op2),
    .eu_issue_valid (eu_issue_valid),
    .eu_issue_ready (eu_issue_ready),
    .eu_result_tag  (eu_result_tag),
    .eu_op_a_data   (eu_op_a_data),
    .eu_op_a_valid  (eu_op_a_valid),
    .eu_op_b_data   (eu_op_b_data),
    .eu_op_b_valid  (eu_op_b_valid),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .dbg_state      (dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_val [RC];
  logic          m_vld [RC];
  logic          m_wait, m_show;
  int            m_oreg;
  logic [DW-1:0] m_odata;

  logic [DW-1:0] n_val [RC];
  logic          n_vld [RC];
  logic [DW:0]   ra, rb, ro;
  logic          e_idle, e_ready, e_fire;
  logic [EC-1:0] e_issue;
  int            e_sel;

  task automatic model_reset();
    for (int r = 0; r < RC; r++) begin
      m_val[r] = '0;
      m_vld[r] = 1'b1;
    end
    m_wait  = 1'b0;
    m_show  = 1'b0;
    m_oreg  = 0;
    m_odata = '0;
  endtask

  function automatic logic [DW:0] m_read(input int a);
    if (m_vld[a]) return {1'b1, m_val[a]};
    if (cdb_in_valid && (m_val[a][TW-1:0] == cdb_in_tag)) return {1'b1, cdb_in_data};
    return {1'b0, m_val[a]};
  endfunction

  // Compare process: mid-cycle, after inputs settle, before the next rising edge.
  always begin
    @(negedge clk);
    #2;
    if (!rst_n) model_reset();
    e_idle  = !(m_wait || m_show);
    ra      = m_read(int'(cmd_op1));
    rb      = m_read(int'(cmd_op2[AW-1:0]));
    ro      = m_read(m_oreg);
    e_ready = e_idle && ((cmd_kind == 3'd1) ? (eu_issue_ready != '0) : 1'b1);
    e_issue = (cmd_valid && cmd_kind == 3'd1 && e_idle) ?
              (eu_issue_ready & (~eu_issue_ready + EC'(1))) : '0;
    check("cmd_ready", 32'(cmd_ready), 32'(e_ready));
    check("eu_issue_valid", 32'(eu_issue_valid), 32'(e_issue));
    check("op_a_data", 32'(eu_op_a_data), (e_issue != '0) ? 32'(ra[DW-1:0]) : 32'd0);
    check("op_a_valid", 32'(eu_op_a_valid), (e_issue != '0) ? 32'(ra[DW]) : 32'd0);
    check("op_b_data", 32'(eu_op_b_data), (e_issue != '0) ? 32'(rb[DW-1:0]) : 32'd0);
    check("op_b_valid", 32'(eu_op_b_valid), (e_issue != '0) ? 32'(rb[DW]) : 32'd0);
    check("out_valid", 32'(out_valid), 32'(m_show));
    check("out_data", 32'(out_data), 32'(m_odata));
    if (rst_n) begin
      n_val  = m_val;
      n_vld  = m_vld;
      e_fire = cmd_valid && e_ready;
      for (int r = 0; r < RC; r++) begin
        if (cdb_in_valid && !m_vld[r] && (m_val[r][TW-1:0] == cdb_in_tag)) begin
          n_val[r] = cdb_in_data;
          n_vld[r] = 1'b1;
        end
      end
      if (e_fire && cmd_kind == 3'd2) begin
        n_val[0] = cmd_op2[DW-1:0];
        n_vld[0] = 1'b1;
      end else if (e_fire && cmd_kind == 3'd1) begin
        e_sel = 0;
        for (int i = EC - 1; i >= 0; i--) if (eu_issue_ready[i]) e_sel = i;
        n_val[0] = DW'(eu_result_tag[e_sel*TW +: TW]);
        n_vld[0] = 1'b0;
      end else if (e_fire && cmd_kind == 3'd3) begin
        n_val[int'(cmd_op2[AW-1:0])] = ra[DW-1:0];
        n_vld[int'(cmd_op2[AW-1:0])] = ra[DW];
      end
      if (e_fire && cmd_kind == 3'd4) begin
        m_oreg = int'(cmd_op1);
        if (ra[DW]) begin
          m_odata = ra[DW-1:0];
          m_show  = 1'b1;
        end else begin
          m_wait = 1'b1;
        end
      end else if (m_wait && ro[DW]) begin
        m_odata = ro[DW-1:0];
        m_wait  = 1'b0;
        m_show  = 1'b1;
      end else if (m_show && out_ready) begin
        m_show = 1'b0;
      end
      m_val = n_val;
      m_vld = n_vld;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input logic v, input int kind, input int op1, input int op2);
    cmd_valid = v;
    cmd_kind  = KW'(kind);
    cmd_op1   = AW'(op1);
    cmd_op2   = OW'(op2);
  endtask

  task automatic set_cdb(input logic v, input int tag, input int data);
    cdb_in_valid = v;
    cdb_in_tag   = TW'(tag);
    cdb_in_data  = DW'(data);
  endtask

  task automatic step();
    @(negedge clk);
    set_cmd(1'b0, 0, 0, 0);
    set_cdb(1'b0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    set_cmd(1'b0, 0, 0, 0);
    set_cdb(1'b0, 0, 0);
    eu_issue_ready = '0;
    eu_result_tag  = '0;
    out_ready      = 1'b0;
    repeat (3) @(negedge clk);
    #3;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset issue", 32'(eu_issue_valid), 32'd0);
    check("reset cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // IMM 5 into ACC, then OUT of ACC
    step(); set_cmd(1'b1, 2, 0, 5); out_ready = 1'b1;
    step(); set_cmd(1'b1, 4, 0, 0);
    #3 check("out not yet", 32'(out_valid), 32'd0);
    step();
    #3 check("imm out_valid", 32'(out_valid), 32'd1);
    check("imm out_data", 32'(out_data), 32'd5);
    step();
    #3 check("out released", 32'(out_valid), 32'd0);

    // ALU issue to EU1 with tag 3
    step(); eu_issue_ready = 2'b10; eu_result_tag = {4'd3, 4'd0}; set_cmd(1'b1, 1, 1, 2);
    #3 check("alu issue", 32'(eu_issue_valid), 32'b10);
    check("alu op_a", 32'({eu_op_a_valid, eu_op_a_data}), 32'h10);
    check("alu op_b", 32'({eu_op_b_valid, eu_op_b_data}), 32'h10);

    // OUT of pending ACC, resolved by CDB 3/9
    step(); eu_issue_ready = '0; out_ready = 1'b0; set_cmd(1'b1, 4, 0, 0);
    step(); set_cmd(1'b1, 0, 0, 0);
    #3 check("wait cmd_ready", 32'(cmd_ready), 32'd0);
    step(); set_cdb(1'b1, 3, 9);
    #3 check("wait out_valid", 32'(out_valid), 32'd0);
    step();
    #3 check("cdb out_data", 32'(out_data), 32'd9);
    for (int k = 0; k < 3; k++) begin
      step();
      #3 check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold out_data", 32'(out_data), 32'd9);
    end
    step(); out_ready = 1'b1;
    step();
    #3 check("hold released", 32'(out_valid), 32'd0);

    // ALU tag 5, then COPY 0->4 while CDB broadcasts 5/7
    step(); eu_issue_ready = 2'b01; eu_result_tag = {4'd0, 4'd5}; set_cmd(1'b1, 1, 0, 0);
    #3 check("alu2 op_a", 32'({eu_op_a_valid, eu_op_a_data}), 32'h19);
    step(); eu_issue_ready = '0; set_cmd(1'b1, 3, 0, 4); set_cdb(1'b1, 5, 7);
    step(); set_cmd(1'b1, 4, 4, 0);
    step();
    #3 check("copy bypass", 32'({out_valid, out_data}), 32'h17);

    // IMM vs same-cycle CDB on ACC's tag; ALU stalls with no ready EU
    step(); eu_issue_ready = 2'b01; eu_result_tag = {4'd0, 4'd6}; set_cmd(1'b1, 1, 1, 1);
    step(); eu_issue_ready = '0; set_cmd(1'b1, 2, 0, 10); set_cdb(1'b1, 6, 12);
    for (int k = 0; k < 2; k++) begin
      step(); set_cmd(1'b1, 1, 0, 0);
      #3 check("stall ready", 32'(cmd_ready), 32'd0);
      check("stall issue", 32'(eu_issue_valid), 32'd0);
    end
    step(); set_cmd(1'b1, 4, 0, 0);
    step();
    #3 check("dispatch wins", 32'({out_valid, out_data}), 32'h1A);

    // Asynchronous reset while presenting
    step(); out_ready = 1'b0; set_cmd(1'b1, 4, 4, 0);
    step();
    #3 check("present", 32'(out_valid), 32'd1);
    step();
    #1 rst_n = 1'b0;
    #1 check("async out_valid", 32'(out_valid), 32'd0);
    check("async state", 32'(dbg_state), 32'(ST_IDLE));
    step(); rst_n = 1'b1;
    #3 check("post reset ready", 32'(cmd_ready), 32'd1);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      set_cmd(($urandom_range(0, 9) < 7), int'($urandom_range(0, 7)),
              int'($urandom_range(0, RC - 1)), int'($urandom_range(0, 15)));
      set_cdb(($urandom_range(0, 9) < 4), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
      eu_issue_ready = EC'($urandom_range(0, 3));
      eu_result_tag  = {TW'($urandom_range(0, 3)), TW'($urandom_range(0, 3))};
      out_ready      = ($urandom_range(0, 9) < 6);
    end

    @(negedge clk);
    #4;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
